alu_branch_unit: RTL and testbench
==================================

# alu_branch_unit

Datapath core of the 8-bit single-cycle processor. It holds the negation and immediate operand selects, the 8-bit ALU with zero flag, and the branch/jump next-PC selection driving a 32-bit program-counter register. It sits between the register file (operand source / result sink) and instruction memory (PC consumer). The decoder and register file are external.

## Interface
Parameters: none.

Ports:
- CLK  in  1  clock; PC register updates on rising edge.
- RESET  in  1  synchronous, active-high; clears PC.
- data1  in  8  operand 1 (register-file read port 1).
- regout2  in  8  register-file read port 2.
- immediate  in  8  instruction bits [7:0].
- offset  in  8  instruction bits [23:16]; signed word offset for jump/beq.
- aluop  in  3  ALU function select.
- negselect  in  1  1 = use two's complement of regout2.
- imselect  in  1  1 = operand 2 is immediate.
- jumpselect  in  1  unconditional jump.
- beqselect  in  1  branch if ALU result is zero.
- alu_result  out  8  combinational ALU result.
- zero  out  1  1 when alu_result == 8'h00.
- pc  out  32  program counter register.

## Operation
- neg_out = negselect ? (8'h00 − regout2) mod 256 : regout2. −0x80 yields 0x80.
- data2 = imselect ? immediate : neg_out.
- ALU, all results modulo 256:
  - 000 FORWARD → data2.
  - 001 ADD → data1 + data2, carry discarded. SUB is ADD with negselect=1.
  - 010 AND → data1 & data2.
  - 011 OR → data1 | data2.
  - 100–111 reserved → 8'h00 (so zero=1).
- zero = (alu_result == 0). Combinational; not registered.
- pc_plus4 = pc + 4.
- target = pc_plus4 + {sign-extended offset[7:0] to 30 bits, 2'b00}. 32-bit wrap, no overflow detection.
- take = jumpselect | (beqselect & zero).
- pc_next = take ? target : pc_plus4.
- Simultaneous jumpselect and beqselect: take is 1, jump wins regardless of zero.
- ALU output is ignored for control when beqselect=0, so jumps are independent of aluop.

## Timing
- All of neg/imm muxes, ALU, zero, target and pc_next are combinational within the cycle. The design contains no modelled delays.
- Rising CLK edge: if RESET, pc ← 32'h0000_0000; else pc ← pc_next.
- RESET has priority over any jump/branch in the same cycle. Reset mid-run takes effect at the next edge. pc stays 0 while RESET is held.
- Reset value: pc = 0. alu_result and zero follow inputs at all times, including during reset.
- Latency: pc reflects a branch/jump decision one edge after the instruction's inputs are stable.

## Configuration
- BNE_EN defined:
  - Adds input bneselect (1 bit).
  - take = jumpselect | (beqselect & zero) | (bneselect & ~zero).
- BNE_EN undefined:
  - Port bneselect is absent.
  - take excludes the bne term.

## Test plan
- Load immediate: aluop=000, imselect=1, immediate=0x2A → alu_result=0x2A, zero=0. pc advances by 4 per edge.
- ADD wrap: data1=0xF0, regout2=0x20, aluop=001, imselect=0, negselect=0 → alu_result=0x10, zero=0.
- BEQ taken: pc=0x10, data1=5, regout2=5, aluop=001, negselect=1, beqselect=1, offset=0x02 → zero=1; next pc=0x1C. With regout2=6 → zero=0, next pc=0x14.
- Jump backward: pc=0x20, jumpselect=1, offset=0xFE, aluop=111 → alu_result=0x00; next pc=0x1C.
- Reset mid-run: RESET=1 with jumpselect=1 at pc=0x1C → pc=0 after edge, and pc stays 0 while RESET is held. After release, pc=0x04 at the next edge.
- Negation edge: regout2=0x80, negselect=1, aluop=000 → alu_result=0x80. AND 0xCC with 0xAA → 0x88. OR → 0xEE.

Source files
------------

// File: rtl/alu_branch_unit.sv
// Datapath core: operand negate/immediate selects, 8-bit ALU with zero flag, and branch/jump PC.
// Optional BNE_EN macro adds a bneselect input for branch-if-not-zero.
module alu_branch_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  data1,
  input  logic [7:0]  regout2,
  input  logic [7:0]  immediate,
  input  logic [7:0]  offset,
  input  logic [2:0]  aluop,
  input  logic        negselect,
  input  logic        imselect,
  input  logic        jumpselect,
  input  logic        beqselect,
`ifdef BNE_EN
  input  logic        bneselect,
`endif
  output logic [7:0]  alu_result,
  output logic        zero,
  output logic [31:0] pc
);

  logic [7:0]  neg_out;
  logic [7:0]  data2;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        take;

  assign neg_out = negselect ? (8'h00 - regout2) : regout2;
  assign data2   = imselect ? immediate : neg_out;

  always_comb begin
    alu_result = 8'h00;
    case (aluop)
      3'b000:  alu_result = data2;
      3'b001:  alu_result = data1 + data2;
      3'b010:  alu_result = data1 & data2;
      3'b011:  alu_result = data1 | data2;
      default: alu_result = 8'h00;
    endcase
  end

  assign zero = (alu_result == 8'h00);

  // Offset counts words, so it is sign-extended and scaled by 4.
  assign pc_plus4 = pc_q + 32'd4;
  assign target   = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};

`ifdef BNE_EN
  assign take = jumpselect | (beqselect & zero) | (bneselect & ~zero);
`else
  assign take = jumpselect | (beqselect & zero);
`endif

  assign pc_d = take ? target : pc_plus4;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q <= 32'h0000_0000;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed bench for alu_branch_unit: ALU vector table plus hand-written PC sequences.
module tb_alu_branch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  data1, regout2, immediate, offset;
  logic [2:0]  aluop;
  logic        negselect, imselect, jumpselect, beqselect;
`ifdef BNE_EN
  logic        bneselect = 1'b0;
`endif
  logic [7:0]  alu_result;
  logic        zero;
  logic [31:0] pc;

  int passed = 0;
  int total  = 0;

  alu_branch_unit dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .data1      (data1),
    .regout2    (regout2),
    .immediate  (immediate),
    .offset     (offset),
    .aluop      (aluop),
    .negselect  (negselect),
    .imselect   (imselect),
    .jumpselect (jumpselect),
    .beqselect  (beqselect),
`ifdef BNE_EN
    .bneselect  (bneselect),
`endif
    .alu_result (alu_result),
    .zero       (zero),
    .pc         (pc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d1;
    logic [7:0] r2;
    logic [7:0] imm;
    logic [2:0] op;
    logic       neg;
    logic       ims;
    logic [7:0] exp_res;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // d1, r2, imm, op, neg, ims, result, zero
    vecs[0] = '{8'h00, 8'h00, 8'h2A, 3'b000, 1'b0, 1'b1, 8'h2A, 1'b0}; // load immediate
    vecs[1] = '{8'hF0, 8'h20, 8'h00, 3'b001, 1'b0, 1'b0, 8'h10, 1'b0}; // add wrap
    vecs[2] = '{8'h05, 8'h05, 8'h00, 3'b001, 1'b1, 1'b0, 8'h00, 1'b1}; // sub equal
    vecs[3] = '{8'h05, 8'h06, 8'h00, 3'b001, 1'b1, 1'b0, 8'hFF, 1'b0}; // sub negative
    vecs[4] = '{8'h00, 8'h80, 8'h00, 3'b000, 1'b1, 1'b0, 8'h80, 1'b0}; // -0x80
    vecs[5] = '{8'h00, 8'h01, 8'h00, 3'b000, 1'b1, 1'b0, 8'hFF, 1'b0}; // -1
    vecs[6] = '{8'hCC, 8'hAA, 8'h00, 3'b010, 1'b0, 1'b0, 8'h88, 1'b0}; // and
    vecs[7] = '{8'hCC, 8'hAA, 8'h00, 3'b011, 1'b0, 1'b0, 8'hEE, 1'b0}; // or
    vecs[8] = '{8'hFF, 8'hFF, 8'h55, 3'b111, 1'b0, 1'b1, 8'h00, 1'b1}; // reserved
    vecs[9] = '{8'h0F, 8'hFF, 8'hF0, 3'b010, 1'b0, 1'b1, 8'h00, 1'b1}; // and imm -> zero

    RESET = 1'b1;
    data1 = 8'h00; regout2 = 8'h00; immediate = 8'h00; offset = 8'h00;
    aluop = 3'b000; negselect = 1'b0; imselect = 1'b0;
    jumpselect = 1'b0; beqselect = 1'b0;
    tick();
    check("reset_pc", pc, 32'h0);

    // Combinational ALU table, evaluated while reset holds pc at 0
    for (int i = 0; i < 10; i++) begin
      data1 = vecs[i].d1; regout2 = vecs[i].r2; immediate = vecs[i].imm;
      aluop = vecs[i].op; negselect = vecs[i].neg; imselect = vecs[i].ims;
      #1;
      check($sformatf("alu_res[%0d]", i), {24'h0, alu_result}, {24'h0, vecs[i].exp_res});
      check($sformatf("zero[%0d]", i), {31'h0, zero}, {31'h0, vecs[i].exp_zero});
    end
    check("pc_held_in_reset", pc, 32'h0);

    // Load immediate while pc advances by 4 per edge
    data1 = 8'h00; aluop = 3'b000; imselect = 1'b1; negselect = 1'b0; immediate = 8'h2A;
    RESET = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("seq_pc[%0d]", i), pc, 32'h4 * i);
    end

    // BEQ taken at 0x10
    data1 = 8'd5; regout2 = 8'd5; aluop = 3'b001; negselect = 1'b1; imselect = 1'b0;
    beqselect = 1'b1; offset = 8'h02;
    #1;
    check("beq_zero", {31'h0, zero}, 32'h1);
    tick();
    check("beq_taken_pc", pc, 32'h1C);

    // BEQ not taken
    regout2 = 8'd6;
    #1;
    check("beq_nz", {31'h0, zero}, 32'h0);
    tick();
    check("beq_not_taken_pc", pc, 32'h20);

    // Jump backward with reserved aluop
    beqselect = 1'b0; jumpselect = 1'b1; offset = 8'hFE; aluop = 3'b111;
    #1;
    check("jmp_alu", {24'h0, alu_result}, 32'h0);
    tick();
    check("jmp_back_pc", pc, 32'h1C);

    // Reset wins over jump and holds pc at 0
    RESET = 1'b1;
    tick();
    check("reset_over_jump", pc, 32'h0);
    tick();
    check("reset_hold", pc, 32'h0);
    RESET = 1'b0; jumpselect = 1'b0;
    tick();
    check("after_reset_pc", pc, 32'h4);

    // Jump and beq together with zero=0: jump still taken
    data1 = 8'd5; regout2 = 8'd6; aluop = 3'b001; negselect = 1'b1;
    jumpselect = 1'b1; beqselect = 1'b1; offset = 8'h01;
    tick();
    check("jmp_beq_pc", pc, 32'h0C);

    // Large negative offset wrapping below zero
    beqselect = 1'b0; offset = 8'h80;
    tick();
    check("jmp_wrap_pc", pc, 32'h10 - 32'd512);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
